// File: rtl/countdown_timer_ctrl_if.sv
// Signal bundle between the countdown controller, the button front end,
// the 1 Hz divider and the 7-segment display driver.
interface countdown_timer_ctrl_if;
  logic        tick;
  logic        btn_start;
  logic        btn_clear;
  logic        load;
  logic [15:0] load_bcd;
  logic        div_ce;
  logic        div_reset;
  logic [15:0] time_bcd;
  logic [1:0]  state;
  logic        alarm;
  logic        load_err;

  // Environment side: drives commands and the divider tick, observes status.
  modport master (
    output tick, btn_start, btn_clear, load, load_bcd,
    input  div_ce, div_reset, time_bcd, state, alarm, load_err
  );

  // Controller side.
  modport slave (
    input  tick, btn_start, btn_clear, load, load_bcd,
    output div_ce, div_reset, time_bcd, state, alarm, load_err
  );
endinterface

// File: rtl/countdown_timer_ctrl.sv
// Countdown timer controller: BCD mm:ss count-down with start/pause/resume/
// clear, a timed alarm on expiry, and CE/reset sequencing of the 1 Hz divider.
module countdown_timer_ctrl #(
  parameter int ALARM_SECS = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  countdown_timer_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] time_q, time_d;
  logic [7:0]  acnt_q, acnt_d;
  logic        alarm_q;
  logic        load_err_q, load_err_d;
  logic        start_idle;
  logic [15:0] time_dec;

  // A load is legal only if every digit is BCD and both tens digits are <= 5.
  function automatic logic load_ok(input logic [15:0] v);
    logic ok;
    ok = (v[15:12] <= 4'd5) && (v[11:8] <= 4'd9) &&
         (v[7:4]   <= 4'd5) && (v[3:0]  <= 4'd9);
    return ok;
  endfunction

  // One-second BCD decrement with borrow chain; 00:00 is held, never wrapped.
  function automatic logic [15:0] bcd_dec(input logic [15:0] t);
    logic [3:0] mt, mo, st, so;
    {mt, mo, st, so} = t;
    if (t == 16'h0000) begin
      return 16'h0000;
    end
    if (so != 4'd0) begin
      so = so - 4'd1;
    end else begin
      so = 4'd9;
      if (st != 4'd0) begin
        st = st - 4'd1;
      end else begin
        st = 4'd5;
        if (mo != 4'd0) begin
          mo = mo - 4'd1;
        end else begin
          mo = 4'd9;
          mt = mt - 4'd1;
        end
      end
    end
    return {mt, mo, st, so};
  endfunction

  assign time_dec = bcd_dec(time_q);

  // Next-state, next-time, alarm counter and load rejection, by priority
  // clear > load > start > tick within each state.
  always_comb begin
    state_d    = state_q;
    time_d     = time_q;
    acnt_d     = acnt_q;
    load_err_d = 1'b0;
    start_idle = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.btn_clear) begin
          time_d = 16'h0000;
        end else if (bus.load) begin
          if (load_ok(bus.load_bcd)) begin
            time_d = bus.load_bcd;
          end else begin
            load_err_d = 1'b1;
          end
        end else if (bus.btn_start && (time_q != 16'h0000)) begin
          state_d    = RUN;
          start_idle = 1'b1;
        end
      end
      RUN: begin
        if (bus.btn_clear) begin
          state_d = IDLE;
          time_d  = 16'h0000;
        end else if (bus.tick) begin
          time_d = time_dec;
          if (time_dec == 16'h0000) begin
            state_d = DONE;
            acnt_d  = 8'd0;
          end else if (bus.btn_start) begin
            state_d = PAUSE;
          end
        end else if (bus.btn_start) begin
          state_d = PAUSE;
        end
      end
      PAUSE: begin
        if (bus.btn_clear) begin
          state_d = IDLE;
          time_d  = 16'h0000;
        end else if (bus.btn_start) begin
          state_d = RUN;
        end
      end
      DONE: begin
        if (bus.btn_clear || bus.btn_start) begin
          state_d = IDLE;
          acnt_d  = 8'd0;
        end else if (bus.tick) begin
          if (acnt_q == 8'(ALARM_SECS - 1)) begin
            state_d = IDLE;
            acnt_d  = 8'd0;
          end else begin
            acnt_d = acnt_q + 8'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, time, alarm counter and registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      time_q     <= 16'h0000;
      acnt_q     <= 8'd0;
      alarm_q    <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      time_q     <= time_d;
      acnt_q     <= acnt_d;
      alarm_q    <= (state_d == DONE);
      load_err_q <= load_err_d;
    end
  end

  // Divider runs while counting or timing the alarm; it is restarted on a
  // fresh start so the first second is a whole one, but not on resume.
  assign bus.div_ce    = (state_q == RUN) || (state_q == DONE);
  assign bus.div_reset = reset | start_idle;
  assign bus.time_bcd  = time_q;
  assign bus.state     = state_q;
  assign bus.alarm     = alarm_q;
  assign bus.load_err  = load_err_q;

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// Bench for countdown_timer_ctrl: directed stimulus pushes hand-derived
// expectations into a queue; a monitor pops one entry per driven cycle.
module tb_countdown_timer_ctrl;

  localparam logic [1:0] SI = 2'd0, SR = 2'd1, SP = 2'd2, SD = 2'd3;

  logic clk;
  logic reset;

  countdown_timer_ctrl_if bus ();

  countdown_timer_ctrl #(.ALARM_SECS(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    bit          cc;
    bit          edr;
    bit          ece;
    logic [1:0]  es;
    logic [15:0] et;
    bit          eal;
    bit          elr;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   ncyc  = 0;

  task automatic check(input string name, input int idx,
                       input logic [15:0] act, input logic [15:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", name, idx, act, req);
    end
  endtask

  // Seconds count to mm:ss BCD via division and modulo.
  function automatic logic [15:0] to_bcd(input int s);
    int m, x;
    m = s / 60;
    x = s % 60;
    return {4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
  endfunction

  // Drive one cycle of inputs at the falling edge and queue what should follow.
  task automatic cyc(input bit r, input bit st, input bit cl, input bit ld,
                     input bit tk, input logic [15:0] lb, input bit cc,
                     input bit edr, input bit ece, input logic [1:0] es,
                     input logic [15:0] et, input bit eal, input bit elr);
    exp_t e;
    @(negedge clk);
    reset         = r;
    bus.btn_start = st;
    bus.btn_clear = cl;
    bus.load      = ld;
    bus.tick      = tk;
    bus.load_bcd  = lb;
    e.idx = ncyc; e.cc = cc; e.edr = edr; e.ece = ece;
    e.es = es; e.et = et; e.eal = eal; e.elr = elr;
    q.push_back(e);
    ncyc++;
  endtask

  // Monitor: combinational outputs before the edge, registered ones after it.
  initial begin
    exp_t e;
    logic drst, dce;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() != 0) begin
        e    = q.pop_front();
        drst = bus.div_reset;
        dce  = bus.div_ce;
        @(posedge clk);
        #1;
        check("div_reset", e.idx, 16'(drst), 16'(e.edr));
        if (e.cc) check("div_ce", e.idx, 16'(dce), 16'(e.ece));
        check("state", e.idx, 16'(bus.state), 16'(e.es));
        check("time_bcd", e.idx, bus.time_bcd, e.et);
        check("alarm", e.idx, 16'(bus.alarm), 16'(e.eal));
        check("load_err", e.idx, 16'(bus.load_err), 16'(e.elr));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    reset = 1'b1; bus.btn_start = 1'b0; bus.btn_clear = 1'b0;
    bus.load = 1'b0; bus.tick = 1'b0; bus.load_bcd = 16'h0000;

    // Reset
    cyc(1,0,0,0,0,16'h0000, 0, 1,0,SI,16'h0000,0,0);
    cyc(1,0,0,0,0,16'h0000, 1, 1,0,SI,16'h0000,0,0);

    // Load 01:05, start, 65 ticks to expiry
    cyc(0,0,0,1,0,16'h0105, 1, 0,0,SI,16'h0105,0,0);
    cyc(0,1,0,0,0,16'h0000, 1, 1,0,SR,16'h0105,0,0);
    for (int k = 1; k <= 65; k++)
      cyc(0,0,0,0,1,16'h0000, 1, 0,1,(k == 65) ? SD : SR, to_bcd(65 - k), k == 65, 0);

    // Alarm times out after 10 ticks
    for (int k = 1; k <= 10; k++)
      cyc(0,0,0,0,1,16'h0000, 1, 0,1,(k == 10) ? SI : SD, 16'h0000, k < 10, 0);
    cyc(0,0,0,0,0,16'h0000, 1, 0,0,SI,16'h0000,0,0);

    // Alarm acknowledged by start after 3 ticks
    cyc(0,0,0,1,0,16'h0002, 1, 0,0,SI,16'h0002,0,0);
    cyc(0,1,0,0,0,16'h0000, 1, 1,0,SR,16'h0002,0,0);
    cyc(0,0,0,0,1,16'h0000, 1, 0,1,SR,16'h0001,0,0);
    cyc(0,0,0,0,1,16'h0000, 1, 0,1,SD,16'h0000,1,0);
    for (int k = 1; k <= 3; k++)
      cyc(0,0,0,0,1,16'h0000, 1, 0,1,SD,16'h0000,1,0);
    cyc(0,1,0,0,0,16'h0000, 1, 0,1,SI,16'h0000,0,0);

    // Pause / resume
    cyc(0,0,0,1,0,16'h0030, 1, 0,0,SI,16'h0030,0,0);
    cyc(0,1,0,0,0,16'h0000, 1, 1,0,SR,16'h0030,0,0);
    for (int k = 1; k <= 5; k++)
      cyc(0,0,0,0,1,16'h0000, 1, 0,1,SR,to_bcd(30 - k),0,0);
    cyc(0,1,0,0,0,16'h0000, 1, 0,1,SP,16'h0025,0,0);
    for (int k = 1; k <= 3; k++)
      cyc(0,0,0,0,1,16'h0000, 1, 0,0,SP,16'h0025,0,0);
    cyc(0,0,0,1,0,16'h0100, 1, 0,0,SP,16'h0025,0,0);
    cyc(0,1,0,0,0,16'h0000, 1, 0,0,SR,16'h0025,0,0);
    for (int k = 1; k <= 25; k++)
      cyc(0,0,0,0,1,16'h0000, 1, 0,1,(k == 25) ? SD : SR, to_bcd(25 - k), k == 25, 0);
    // Full 10-tick alarm again: counter must have been cleared by the earlier ack
    for (int k = 1; k <= 10; k++)
      cyc(0,0,0,0,1,16'h0000, 1, 0,1,(k == 10) ? SI : SD, 16'h0000, k < 10, 0);

    // Load validation
    cyc(0,0,0,1,0,16'h0A00, 1, 0,0,SI,16'h0000,0,1);
    cyc(0,0,0,0,0,16'h0000, 1, 0,0,SI,16'h0000,0,0);
    cyc(0,0,0,1,0,16'h0060, 1, 0,0,SI,16'h0000,0,1);
    cyc(0,0,0,1,0,16'h5959, 1, 0,0,SI,16'h5959,0,0);
    cyc(0,0,0,1,0,16'h6000, 1, 0,0,SI,16'h5959,0,1);
    cyc(0,0,1,0,0,16'h0000, 1, 0,0,SI,16'h0000,0,0);
    cyc(0,1,0,0,0,16'h0000, 1, 0,0,SI,16'h0000,0,0);
    cyc(0,0,0,0,1,16'h0000, 1, 0,0,SI,16'h0000,0,0);

    // Start and tick together at 00:01
    cyc(0,0,0,1,0,16'h0002, 1, 0,0,SI,16'h0002,0,0);
    cyc(0,1,0,0,0,16'h0000, 1, 1,0,SR,16'h0002,0,0);
    cyc(0,0,0,0,1,16'h0000, 1, 0,1,SR,16'h0001,0,0);
    cyc(0,1,0,0,1,16'h0000, 1, 0,1,SD,16'h0000,1,0);
    cyc(0,1,0,0,0,16'h0000, 1, 0,1,SI,16'h0000,0,0);

    // Start and tick together mid-count pauses after the decrement
    cyc(0,0,0,1,0,16'h0100, 1, 0,0,SI,16'h0100,0,0);
    cyc(0,1,0,0,0,16'h0000, 1, 1,0,SR,16'h0100,0,0);
    cyc(0,1,0,0,1,16'h0000, 1, 0,1,SP,16'h0059,0,0);

    // Clear and tick together while running
    cyc(0,1,0,0,0,16'h0000, 1, 0,0,SR,16'h0059,0,0);
    cyc(0,0,0,0,1,16'h0000, 1, 0,1,SR,16'h0058,0,0);
    cyc(0,0,1,0,1,16'h0000, 1, 0,1,SI,16'h0000,0,0);

    // Load and start together in IDLE, then clear beats load
    cyc(0,1,0,1,0,16'h0010, 1, 0,0,SI,16'h0010,0,0);
    cyc(0,0,1,1,0,16'h0030, 1, 0,0,SI,16'h0000,0,0);

    // Reset mid-run at 00:42
    cyc(0,0,0,1,0,16'h0043, 1, 0,0,SI,16'h0043,0,0);
    cyc(0,1,0,0,0,16'h0000, 1, 1,0,SR,16'h0043,0,0);
    cyc(0,0,0,0,1,16'h0000, 1, 0,1,SR,16'h0042,0,0);
    cyc(1,0,0,0,1,16'h0000, 1, 1,1,SI,16'h0000,0,0);
    cyc(0,0,0,0,0,16'h0000, 1, 0,0,SI,16'h0000,0,0);

    repeat (3) @(negedge clk);
    check("queue_drained", ncyc, 16'(q.size()), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/countdown_timer_ctrl.md
Name: countdown_timer_ctrl

Overview:
Countdown-timer controller that sequences the 1 Hz clock-enable divider. It drives the divider's CE and reset, and consumes the divider's 1 Hz enable pulse (`tick`). It keeps a BCD mm:ss count from 59:59 down to 00:00, with start/pause/resume/clear control. When the count expires it raises a timed alarm. It sits between the debounced push-button front end and the 7-segment display driver.

Parameters:
ALARM_SECS, 10, number of ticks the alarm stays asserted in DONE before auto-return to IDLE (range 1..255).

Ports:
clk  input  1  system clock (100 MHz).
reset  input  1  synchronous, active-high reset.
tick  input  1  one-cycle 1 Hz enable from the divider's CEO.
btn_start  input  1  single-cycle pulse: start/pause/resume/acknowledge.
btn_clear  input  1  single-cycle pulse: abort and zero the time.
load  input  1  single-cycle pulse: load load_bcd (IDLE only).
load_bcd  input  16  {min_tens, min_ones, sec_tens, sec_ones}, BCD.
div_ce  output  1  CE to divider.
div_reset  output  1  reset to divider.
time_bcd  output  16  current time, same packing as load_bcd.
state  output  2  0=IDLE, 1=RUN, 2=PAUSE, 3=DONE.
alarm  output  1  high while in DONE.
load_err  output  1  one-cycle pulse: rejected load.

Behaviour:
- Reset: state=IDLE, time_bcd=16'h0000, alarm=0, load_err=0, internal alarm counter=0. All outputs are registered except div_ce and div_reset.
- div_ce is combinational: 1 in RUN and DONE, 0 in IDLE and PAUSE.
- div_reset is combinational: `reset` OR (start accepted in IDLE). This makes the first second after a start a full second.
- Command priority in every state: reset > btn_clear > load > btn_start > tick.
- IDLE:
  - Clear: time <= 0000.
  - Valid load: time <= load_bcd.
  - Invalid load (any nibble >9, sec_tens >5, or min_tens >5): time unchanged; load_err=1 on the next cycle.
  - Start with time≠0000 and no load that cycle: go to RUN and assert div_reset in that cycle.
  - Start with time=0000: ignored.
  - Tick: ignored.
- RUN:
  - Tick: BCD decrement. sec_ones 0→9 with borrow; sec_tens 0→5 with borrow; min_ones 0→9 with borrow; min_tens −1.
  - Tick with time=0001: time <= 0000, go to DONE, alarm counter <= 0.
  - Start without tick: go to PAUSE.
  - Start with tick in the same cycle: decrement is applied and state goes to PAUSE. If that decrement reaches 0000, DONE wins.
  - Clear: go to IDLE, time <= 0000.
  - Load: ignored, no load_err.
- PAUSE:
  - Start: go to RUN. No div_reset, so the partial second is preserved.
  - Clear: go to IDLE, time 0000.
  - Tick and load: ignored.
- DONE:
  - alarm=1 and time stays 0000.
  - Tick increments the alarm counter. A tick with counter = ALARM_SECS−1 goes to IDLE, alarm <= 0.
  - Start or clear: go to IDLE immediately, alarm <= 0, counter <= 0.
  - Load: ignored.
- alarm is registered and equals (next_state==DONE).
- Latency: state and time_bcd update on the clock edge following the qualifying input. load_err follows one cycle after the rejected load.
- Reset asserted in any state, mid-count: all registers return to reset values on that edge. div_reset=1 for the duration of reset.
- Wrap-around: none. The count never decrements below 0000; a tick at 0000 outside RUN has no effect.

Test Plan:
1. Reset, then load 16'h0105, start, 65 ticks → div_reset pulses in the start cycle. time_bcd goes 0105→0104…0100→0059…0001→0000. state=DONE and alarm=1 after tick 65.
2. In DONE, 10 ticks with ALARM_SECS=10 → alarm drops and state=IDLE on the 10th tick, time=0000. Repeat, but pulse btn_start after 3 ticks → IDLE immediately.
3. Load 0030, start, 5 ticks, btn_start → PAUSE with time 0025. Inject 3 ticks → time stays 0025. btn_start → RUN with no div_reset pulse. 25 ticks → DONE.
4. Load 16'h0A00, then 16'h0060 → each sets load_err=1 for one cycle and time stays unchanged. Load 5959 → accepted. btn_start at time 0000 in IDLE → state stays IDLE and div_ce=0.
5. Simultaneous events:
   - RUN at 0001 with btn_start and tick in the same cycle → DONE.
   - RUN with btn_clear and tick in the same cycle → IDLE, 0000.
   - IDLE with load 0010 and btn_start in the same cycle → time=0010, state stays IDLE.
6. reset asserted mid-RUN at 0042 → next edge: IDLE, 0000, alarm=0. div_reset=1 while reset is high.
